// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle instruction sequencer.
// Walks IDLE -> FETCH -> DECODE -> EXEC -> (WB) -> FETCH and owns the
// program counter, the instruction register, the retired-instruction count
// and a sticky fault code. HALT is terminal until reset.
module cpu_controller #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic [31:0] imm,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    // Highest opcode the datapath implements.
    localparam logic [5:0] OPCODE_MAX = 6'd6;

    // Wait count seen in the last FETCH cycle allowed before timing out.
    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    // Wait cycles spent in the current FETCH.
    logic [7:0] wait_cnt;
    // Cleared by reset and set on the first clock edge afterwards, so a start
    // pulse that overlaps reset release cannot launch execution.
    logic       armed;

    // Status outputs are pure decodes of the current state.
    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pc;
        rf_we     = (state == S_WB);
        halted    = (state == S_HALT);
    end

    // Sequencer: state transitions and all architectural register updates.
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see
    // half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 32'h0000_0000;
            retired  <= 32'h0000_0000;
            fault    <= FAULT_NONE;
            wait_cnt <= 8'd0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_HALT;
                        if (fault == FAULT_NONE) fault <= FAULT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (ir[31:26] <= OPCODE_MAX) begin
                        state <= S_EXEC;
                    end else begin
                        state <= S_HALT;
                        if (fault == FAULT_NONE) fault <= FAULT_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (is_jump || is_branch) begin
                        if (is_jump)
                            pc <= {pc[31:28], ir[25:0], 2'b00};
                        else if (alu_zero)
                            pc <= pc + 32'd4 + (imm << 2);
                        else
                            pc <= pc + 32'd4;
                        retired  <= retired + 32'd1;
                        state    <= S_FETCH;
                        wait_cnt <= 8'd0;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc       <= pc + 32'd4;
                    retired  <= retired + 32'd1;
                    state    <= S_FETCH;
                    wait_cnt <= 8'd0;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    // Codes 6 and 7 are never entered legitimately.
                    state <= S_HALT;
                    if (fault == FAULT_NONE) fault <= FAULT_ILLEGAL;
                end
            endcase
        end
    end

endmodule
